// File: rtl/stream_packetizer_if.sv
// stream_packetizer_if: payload stream in, framed packet stream out
// Ports: din/val_in/ready_upward/dest_addr on the upstream side;
//        dout/val_out/last_out/ready_downward on the link side.
// The slave modport is the packetizer; the master modport is its environment.
interface stream_packetizer_if #(parameter int PAYLOAD_BITS = 32);
  logic [PAYLOAD_BITS-1:0] din;
  logic                    val_in;
  logic                    ready_upward;
  logic [7:0]              dest_addr;
  logic [PAYLOAD_BITS-1:0] dout;
  logic                    val_out;
  logic                    last_out;
  logic                    ready_downward;
  modport master (output din, val_in, dest_addr, ready_downward,
                  input  ready_upward, dout, val_out, last_out);
  modport slave  (input  din, val_in, dest_addr, ready_downward,
                  output ready_upward, dout, val_out, last_out);
endinterface

// File: rtl/stream_packetizer.sv
// stream_packetizer: frames raw payload words into header + PKT_LEN word packets
// Ports: clk, reset (async, active-high), link (stream_packetizer_if.slave).
// All link outputs except ready_upward are registered.
module stream_packetizer #(
  parameter int PAYLOAD_BITS = 32,
  parameter int PKT_LEN      = 16,
  parameter int CNT_BITS     = 8
) (
  input logic                 clk,
  input logic                 reset,
  stream_packetizer_if.slave  link
);
  typedef enum logic {IDLE, PAYLOAD} state_t;
  state_t                  r_state, w_next;
  logic [CNT_BITS-1:0]     r_cnt;
  logic [15:0]             r_seq;
  logic [PAYLOAD_BITS-1:0] r_dout, w_hdr;
  logic                    r_val, r_last;
  logic                    w_slot_free, w_ready, w_in_xfer, w_last;
  assign w_slot_free = !r_val || link.ready_downward;
  assign w_in_xfer   = link.val_in && w_ready;
  assign w_last      = r_cnt == CNT_BITS'(PKT_LEN - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE) ? ((link.val_in && w_slot_free) ? PAYLOAD : IDLE)
                               : ((w_in_xfer && w_last) ? IDLE : PAYLOAD);
  always_comb begin
    w_ready = (r_state == PAYLOAD) && w_slot_free;
    w_hdr = '0;
    w_hdr[PAYLOAD_BITS-1 -: 8] = link.dest_addr;
    w_hdr[23:0] = {8'(PKT_LEN), r_seq};
  end
  // IDLE never consumes din; it only loads a header once the slot can take it.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_dout <= '0;
      r_val  <= 1'b0;
      r_last <= 1'b0;
      r_cnt  <= '0;
      r_seq  <= '0;
    end else if (r_state == IDLE) begin
      if (w_slot_free) begin
        r_val  <= link.val_in;
        r_last <= 1'b0;
        if (link.val_in) begin
          r_dout <= w_hdr;
          r_cnt  <= '0;
        end
      end
    end else if (w_in_xfer) begin
      r_dout <= link.din;
      r_val  <= 1'b1;
      r_last <= w_last;
      r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) r_seq <= r_seq + 16'd1;
    end else if (w_slot_free) begin
      r_val  <= 1'b0;
      r_last <= 1'b0;
    end
  assign link.ready_upward = w_ready;
  assign link.dout         = r_dout;
  assign link.val_out      = r_val;
  assign link.last_out     = r_last;
endmodule
